// File: rtl/f_pc_gen.sv
// Fetch-stage PC generator: holds the fetch PC and selects the next one from
// sequential, redirect, exception, ERET and return-address-stack sources.
module f_pc_gen #(
    parameter int unsigned     WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_4180),
    parameter int unsigned     RAS_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          redirect_vld,
    input  logic [WIDTH-1:0]              redirect_pc,
    input  logic                          exc_req,
    input  logic                          eret_req,
    input  logic [WIDTH-1:0]              epc,
    input  logic                          ras_push,
    input  logic [WIDTH-1:0]              ras_push_addr,
    input  logic                          ras_pop,
    output logic [WIDTH-1:0]              pc,
    output logic                          pc_misalign,
    output logic [WIDTH-1:0]              ras_top,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic                          ras_underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [CNT_W-1:0] count_next;
    logic [PTR_W-1:0] wr_idx;
    logic             ras_wr;
    logic             underflow_next;
    logic             ras_en;
    logic             ras_empty;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_seq;

    assign ras_en      = en & ~exc_req & ~eret_req;
    assign ras_empty   = (ras_count == '0);
    assign ras_top     = ras_empty ? '0 : ras_mem[ptr];
    assign pc_misalign = |pc[1:0];
    assign pc_seq      = pc + WIDTH'(4);

    // RAS pointer/count update; a full stack overwrites its oldest entry.
    always_comb begin
        ptr_next       = ptr;
        count_next     = ras_count;
        wr_idx         = ptr;
        ras_wr         = 1'b0;
        underflow_next = 1'b0;
        if (ras_en) begin
            case ({ras_push, ras_pop})
                2'b10: begin
                    ptr_next   = ptr + PTR_W'(1);
                    wr_idx     = ptr + PTR_W'(1);
                    ras_wr     = 1'b1;
                    count_next = (ras_count == CNT_FULL) ? ras_count : ras_count + CNT_W'(1);
                end
                2'b01: begin
                    if (ras_empty) begin
                        underflow_next = 1'b1;
                    end else begin
                        ptr_next   = ptr - PTR_W'(1);
                        count_next = ras_count - CNT_W'(1);
                    end
                end
                2'b11: begin
                    // Call and return together replace the top; on an empty stack it is a plain push.
                    ras_wr = 1'b1;
                    if (ras_empty) begin
                        ptr_next   = ptr + PTR_W'(1);
                        wr_idx     = ptr + PTR_W'(1);
                        count_next = ras_count + CNT_W'(1);
                    end
                end
                default: begin
                    ptr_next = ptr;
                end
            endcase
        end
    end

    // Next-PC priority: exception, ERET, redirect, RAS prediction, sequential, stall.
    always_comb begin
        pc_next = pc;
        if (exc_req) begin
            pc_next = EXC_VEC;
        end else if (eret_req) begin
            pc_next = epc;
        end else if (en) begin
            if (redirect_vld) begin
                pc_next = redirect_pc;
            end else if (ras_pop && !ras_empty) begin
                pc_next = ras_top;
            end else begin
                pc_next = pc_seq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_VEC;
            ptr           <= '0;
            ras_count     <= '0;
            ras_underflow <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            pc            <= pc_next;
            ptr           <= ptr_next;
            ras_count     <= count_next;
            ras_underflow <= underflow_next;
            if (ras_wr) begin
                ras_mem[wr_idx] <= ras_push_addr;
            end
        end
    end

endmodule

// File: tb/tb_f_pc_gen.sv
// Directed bench for f_pc_gen: expected state is queued with each stimulus step
// and compared one cycle later.
module tb_f_pc_gen;

    logic        clk = 1'b0;
    logic        reset, en, redirect_vld, exc_req, eret_req, ras_push, ras_pop;
    logic [31:0] redirect_pc, epc, ras_push_addr;
    logic [31:0] pc, ras_top;
    logic        pc_misalign, ras_underflow;
    logic [3:0]  ras_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  cnt;
        logic [31:0] top;
        logic        uf;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] p;
    logic [31:0] a;

    always #5 clk = ~clk;

    f_pc_gen dut (
        .clk(clk), .reset(reset), .en(en),
        .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
        .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
        .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
        .pc(pc), .pc_misalign(pc_misalign), .ras_top(ras_top),
        .ras_count(ras_count), .ras_underflow(ras_underflow)
    );

    task automatic clear_in();
        reset = 1'b0; en = 1'b0; redirect_vld = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
        ras_push = 1'b0; ras_pop = 1'b0;
        redirect_pc = '0; epc = '0; ras_push_addr = '0;
    endtask

    task automatic expect_next(input logic [31:0] ep, input logic [3:0] ec,
                               input logic [31:0] et, input logic eu);
        exp_t e;
        e.pc = ep; e.cnt = ec; e.top = et; e.uf = eu;
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        exp_t e;
        logic [1:0] lo;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e  = sb.pop_front();
            lo = e.pc[1:0];
            chk("pc", pc, e.pc);
            chk("pc_misalign", 32'(pc_misalign), 32'(lo != 2'b00));
            chk("ras_count", 32'(ras_count), 32'(e.cnt));
            chk("ras_top", ras_top, e.top);
            chk("ras_underflow", 32'(ras_underflow), 32'(e.uf));
        end
    endtask

    initial begin
        clear_in();
        // reset then sequential fetch
        reset = 1'b1;
        expect_next(32'h3000, 4'd0, 32'h0, 1'b0); tick();
        reset = 1'b0; en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            expect_next(32'h3000 + 32'(4 * i), 4'd0, 32'h0, 1'b0); tick();
        end
        // stall, including a redirect that must wait for en
        en = 1'b0;
        repeat (4) begin
            expect_next(32'h3010, 4'd0, 32'h0, 1'b0); tick();
        end
        redirect_vld = 1'b1; redirect_pc = 32'h3400;
        expect_next(32'h3010, 4'd0, 32'h0, 1'b0); tick();
        en = 1'b1;
        expect_next(32'h3400, 4'd0, 32'h0, 1'b0); tick();

        // push two, pop three (last one underflows)
        clear_in(); en = 1'b1; ras_push = 1'b1; ras_push_addr = 32'h3008;
        expect_next(32'h3404, 4'd1, 32'h3008, 1'b0); tick();
        ras_push_addr = 32'h3020;
        expect_next(32'h3408, 4'd2, 32'h3020, 1'b0); tick();
        ras_push = 1'b0; ras_pop = 1'b1;
        expect_next(32'h3020, 4'd1, 32'h3008, 1'b0); tick();
        expect_next(32'h3008, 4'd0, 32'h0, 1'b0); tick();
        expect_next(32'h300C, 4'd0, 32'h0, 1'b1); tick();
        ras_pop = 1'b0;
        expect_next(32'h3010, 4'd0, 32'h0, 1'b0); tick();

        // overfill: nine pushes into eight entries
        p = 32'h3010;
        ras_push = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            a = 32'h5000 + 32'(4 * i);
            ras_push_addr = a;
            p = p + 32'd4;
            expect_next(p, (i >= 7) ? 4'd8 : 4'(i + 1), a, 1'b0); tick();
        end
        ras_push = 1'b0; ras_pop = 1'b1;
        for (int k = 0; k < 8; k++) begin
            expect_next(32'h5000 + 32'(4 * (8 - k)), 4'(7 - k),
                        (k < 7) ? 32'h5000 + 32'(4 * (7 - k)) : 32'h0, 1'b0);
            tick();
        end
        expect_next(32'h5008, 4'd0, 32'h0, 1'b1); tick();

        // exception / eret leave the RAS untouched
        ras_pop = 1'b0; ras_push = 1'b1; ras_push_addr = 32'h3500;
        expect_next(32'h500C, 4'd1, 32'h3500, 1'b0); tick();
        ras_push = 1'b0; en = 1'b0; exc_req = 1'b1; redirect_vld = 1'b1; redirect_pc = 32'h3400;
        expect_next(32'h4180, 4'd1, 32'h3500, 1'b0); tick();
        en = 1'b1; ras_pop = 1'b1;
        expect_next(32'h4180, 4'd1, 32'h3500, 1'b0); tick();
        exc_req = 1'b0; ras_pop = 1'b0; redirect_vld = 1'b0;
        ras_push = 1'b1; ras_push_addr = 32'h3700; eret_req = 1'b1; epc = 32'h3104;
        expect_next(32'h3104, 4'd1, 32'h3500, 1'b0); tick();

        // misaligned redirect and PC wrap
        eret_req = 1'b0; ras_push = 1'b0; redirect_vld = 1'b1; redirect_pc = 32'h3402;
        expect_next(32'h3402, 4'd1, 32'h3500, 1'b0); tick();
        redirect_pc = 32'hFFFF_FFFC;
        expect_next(32'hFFFF_FFFC, 4'd1, 32'h3500, 1'b0); tick();
        redirect_vld = 1'b0;
        expect_next(32'h0000_0000, 4'd1, 32'h3500, 1'b0); tick();

        // simultaneous push and pop replaces the top entry
        ras_push = 1'b1; ras_pop = 1'b1; ras_push_addr = 32'h3600;
        expect_next(32'h3500, 4'd1, 32'h3600, 1'b0); tick();
        ras_push = 1'b0;
        expect_next(32'h3600, 4'd0, 32'h0, 1'b0); tick();

        // reset dominates an in-flight push/pop
        ras_pop = 1'b0; ras_push = 1'b1; ras_push_addr = 32'h3900;
        expect_next(32'h3604, 4'd1, 32'h3900, 1'b0); tick();
        reset = 1'b1; ras_pop = 1'b1; ras_push_addr = 32'h3800;
        expect_next(32'h3000, 4'd0, 32'h0, 1'b0); tick();
        clear_in();
        expect_next(32'h3000, 4'd0, 32'h0, 1'b0); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
